// File: rtl/fmul_s3.sv
// fmul_s3: final stage of the pipelined FP multiplier - normalize, round, pack and flag the product.
// Define FMUL_S3_SKID_BUF_EN for a 2-entry skid buffer with a registered in_ready_o; default is a 1-entry stage.
module fmul_s3 #(
    parameter int EXPWIDTH  = 8,
    parameter int PRECISION = 24
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic                          in_special_case_valid_i,
    input  logic                          in_special_case_nan_i,
    input  logic                          in_special_case_inf_i,
    input  logic                          in_special_case_inv_i,
    input  logic                          in_special_case_haszero_i,
    input  logic                          in_earyl_overflow_i,
    input  logic                          in_prod_sign_i,
    input  logic [EXPWIDTH:0]             in_shift_amt_i,
    input  logic [EXPWIDTH:0]             in_exp_shifted_i,
    input  logic                          in_may_be_subnormal_i,
    input  logic [2:0]                    in_rm_i,
    input  logic [2*PRECISION-1:0]        in_prod_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [EXPWIDTH+PRECISION-1:0] result_o,
    output logic [4:0]                    fflags_o
);

    localparam int W  = 2 * PRECISION;
    localparam int RW = EXPWIDTH + PRECISION;
    localparam int FW = PRECISION - 1;
    localparam int XW = EXPWIDTH + 2;

    logic [W-1:0]  s;
    logic [XW-1:0] exp_pre;
    logic [XW-1:0] exp_rnd;
    logic [FW-1:0] frac;
    logic [FW-1:0] frac_rnd;
    logic [FW:0]   frac_sum;
    logic          guard;
    logic          sticky;
    logic          inexact;
    logic          round_up;
    logic          overflow;
    logic          to_inf;
    logic          tiny;
    logic [RW-1:0] res_c;
    logic [4:0]    flg_c;
    logic          in_fire;
    logic          out_fire;

    assign s        = in_prod_i << in_shift_amt_i;
    assign in_fire  = in_valid_i && in_ready_o;
    assign out_fire = out_valid_o && out_ready_i;

    // The product's leading one sits at bit W-1 or W-2; the other one is the hidden bit.
    always_comb begin
        exp_pre = '0;
        frac    = '0;
        guard   = 1'b0;
        sticky  = 1'b0;
        if (s[W-1]) begin
            exp_pre = XW'(in_exp_shifted_i) + XW'(1);
            frac    = s[W-2 -: FW];
            guard   = s[PRECISION-1];
            sticky  = |s[PRECISION-2:0];
        end else begin
            exp_pre = XW'(in_exp_shifted_i);
            frac    = s[W-3 -: FW];
            guard   = s[PRECISION-2];
            sticky  = |s[PRECISION-3:0];
        end
    end

    always_comb begin
        inexact  = guard | sticky;
        round_up = 1'b0;
        to_inf   = 1'b1;
        case (in_rm_i)
            3'd1: begin round_up = 1'b0;                       to_inf = 1'b0;            end
            3'd2: begin round_up = in_prod_sign_i & inexact;   to_inf = in_prod_sign_i;  end
            3'd3: begin round_up = !in_prod_sign_i & inexact;  to_inf = !in_prod_sign_i; end
            3'd4: begin round_up = guard;                      to_inf = 1'b1;            end
            default: begin round_up = guard & (sticky | frac[0]); to_inf = 1'b1;        end
        endcase
    end

    // A carry out of the fraction wraps it to zero and bumps the exponent.
    always_comb begin
        frac_sum = {1'b0, frac} + {{FW{1'b0}}, round_up};
        frac_rnd = frac_sum[FW-1:0];
        exp_rnd  = exp_pre + {{(XW-1){1'b0}}, frac_sum[FW]};
        overflow = (exp_rnd >= XW'((1 << EXPWIDTH) - 1)) || in_earyl_overflow_i;
        tiny     = in_may_be_subnormal_i && (exp_rnd == '0);
    end

    always_comb begin
        res_c = '0;
        flg_c = '0;
        if (in_special_case_valid_i) begin
            if (in_special_case_nan_i) begin
                res_c = {1'b0, {EXPWIDTH{1'b1}}, 1'b1, {(FW-1){1'b0}}};
            end else if (in_special_case_inf_i) begin
                res_c = {in_prod_sign_i, {EXPWIDTH{1'b1}}, {FW{1'b0}}};
            end else begin
                res_c = {in_prod_sign_i, {(RW-1){1'b0}}};
            end
            flg_c = {in_special_case_inv_i, 4'b0000};
        end else if (overflow) begin
            if (to_inf) begin
                res_c = {in_prod_sign_i, {EXPWIDTH{1'b1}}, {FW{1'b0}}};
            end else begin
                res_c = {in_prod_sign_i, {(EXPWIDTH-1){1'b1}}, 1'b0, {FW{1'b1}}};
            end
            flg_c = 5'b00101;
        end else begin
            res_c = {in_prod_sign_i, exp_rnd[EXPWIDTH-1:0], frac_rnd};
            flg_c = {3'b000, tiny & inexact, inexact};
        end
    end

`ifdef FMUL_S3_SKID_BUF_EN
    logic [RW-1:0] ent_res [2];
    logic [4:0]    ent_flg [2];
    logic          rd_ptr;
    logic          wr_ptr;
    logic [1:0]    count_q;
    logic [1:0]    count_nxt;
    logic          full_q;

    always_comb begin
        count_nxt = count_q;
        case ({in_fire, out_fire})
            2'b10:   count_nxt = count_q + 2'd1;
            2'b01:   count_nxt = count_q - 2'd1;
            default: count_nxt = count_q;
        endcase
    end

    // Ready is registered from the next occupancy so out_ready_i never reaches in_ready_o.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                ent_res[i] <= '0;
                ent_flg[i] <= '0;
            end
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            if (in_fire) begin
                ent_res[wr_ptr] <= res_c;
                ent_flg[wr_ptr] <= flg_c;
                wr_ptr          <= ~wr_ptr;
            end
            if (out_fire) begin
                rd_ptr <= ~rd_ptr;
            end
            count_q <= count_nxt;
            full_q  <= (count_nxt == 2'd2);
        end
    end

    assign in_ready_o  = !full_q;
    assign out_valid_o = (count_q != 2'd0);
    assign result_o    = ent_res[rd_ptr];
    assign fflags_o    = ent_flg[rd_ptr];
`else
    logic          valid_q;
    logic [RW-1:0] res_q;
    logic [4:0]    flg_q;

    // A new entry may overwrite the held one in the same cycle it drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            flg_q   <= '0;
        end else if (in_fire) begin
            valid_q <= 1'b1;
            res_q   <= res_c;
            flg_q   <= flg_c;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign result_o    = res_q;
    assign fflags_o    = flg_q;
`endif

endmodule

// File: tb/tb_fmul_s3.sv
// tb_fmul_s3: directed self-checking bench for fmul_s3 at default parameters (1-entry build).
// Expected results are hand-derived IEEE-754 single-precision encodings.
module tb_fmul_s3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic        in_special_case_valid_i = 1'b0;
    logic        in_special_case_nan_i = 1'b0;
    logic        in_special_case_inf_i = 1'b0;
    logic        in_special_case_inv_i = 1'b0;
    logic        in_special_case_haszero_i = 1'b0;
    logic        in_earyl_overflow_i = 1'b0;
    logic        in_prod_sign_i = 1'b0;
    logic [8:0]  in_shift_amt_i = '0;
    logic [8:0]  in_exp_shifted_i = '0;
    logic        in_may_be_subnormal_i = 1'b0;
    logic [2:0]  in_rm_i = '0;
    logic [47:0] in_prod_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] result_o;
    logic [4:0]  fflags_o;

    int assert_count = 0;
    int fail_count   = 0;

    always #5 clk = ~clk;

    fmul_s3 #(.EXPWIDTH(8), .PRECISION(24)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .in_valid_i                (in_valid_i),
        .in_ready_o                (in_ready_o),
        .in_special_case_valid_i   (in_special_case_valid_i),
        .in_special_case_nan_i     (in_special_case_nan_i),
        .in_special_case_inf_i     (in_special_case_inf_i),
        .in_special_case_inv_i     (in_special_case_inv_i),
        .in_special_case_haszero_i (in_special_case_haszero_i),
        .in_earyl_overflow_i       (in_earyl_overflow_i),
        .in_prod_sign_i            (in_prod_sign_i),
        .in_shift_amt_i            (in_shift_amt_i),
        .in_exp_shifted_i          (in_exp_shifted_i),
        .in_may_be_subnormal_i     (in_may_be_subnormal_i),
        .in_rm_i                   (in_rm_i),
        .in_prod_i                 (in_prod_i),
        .out_valid_o               (out_valid_o),
        .out_ready_i               (out_ready_i),
        .result_o                  (result_o),
        .fflags_o                  (fflags_o)
    );

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        assert_count++;
        assert (obs === exp_v) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] exp_res, input logic [4:0] exp_flg);
        checkValue({tag, " valid"}, {31'd0, out_valid_o}, 32'd1);
        checkValue({tag, " result"}, result_o, exp_res);
        checkValue({tag, " fflags"}, {27'd0, fflags_o}, {27'd0, exp_flg});
    endtask

    // spc packs {valid, nan, inf, inv, haszero}
    task automatic applyStimulus(input logic sign, input logic [8:0] shift, input logic [8:0] expv,
                                 input logic [2:0] rm, input logic [47:0] prod, input logic sub,
                                 input logic eovf, input logic [4:0] spc);
        in_valid_i                = 1'b1;
        in_prod_sign_i            = sign;
        in_shift_amt_i            = shift;
        in_exp_shifted_i          = expv;
        in_rm_i                   = rm;
        in_prod_i                 = prod;
        in_may_be_subnormal_i     = sub;
        in_earyl_overflow_i       = eovf;
        in_special_case_valid_i   = spc[4];
        in_special_case_nan_i     = spc[3];
        in_special_case_inf_i     = spc[2];
        in_special_case_inv_i     = spc[1];
        in_special_case_haszero_i = spc[0];
    endtask

    task automatic runVector(input string tag, input logic sign, input logic [8:0] shift,
                             input logic [8:0] expv, input logic [2:0] rm, input logic [47:0] prod,
                             input logic sub, input logic eovf, input logic [4:0] spc,
                             input logic [31:0] exp_res, input logic [4:0] exp_flg);
        applyStimulus(sign, shift, expv, rm, prod, sub, eovf, spc);
        out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        checkOutput(tag, exp_res, exp_flg);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] q[$];
        int accepts;
        int sent;
        int got;

        $display("[TB] start");
        repeat (2) @(posedge clk);
        #1;
        checkValue("reset valid", {31'd0, out_valid_o}, 32'd0);
        checkValue("reset result", result_o, 32'd0);
        checkValue("reset fflags", {27'd0, fflags_o}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkValue("post-reset ready", {31'd0, in_ready_o}, 32'd1);

        // 1.0 x 1.0: product of two 24-bit significands lands at bit 46, shift 1 brings it to bit 47
        runVector("one_x_one",      1'b0, 9'd1,  9'd126, 3'd0, 48'h4000_0000_0000, 1'b0, 1'b0, 5'b00000, 32'h3F80_0000, 5'h00);
        runVector("eovf_rtz",       1'b0, 9'd0,  9'd0,   3'd1, 48'h0,              1'b0, 1'b1, 5'b00000, 32'h7F7F_FFFF, 5'h05);
        runVector("eovf_rne",       1'b0, 9'd0,  9'd0,   3'd0, 48'h0,              1'b0, 1'b1, 5'b00000, 32'h7F80_0000, 5'h05);
        runVector("special_nan",    1'b0, 9'd0,  9'd0,   3'd0, 48'h0,              1'b0, 1'b0, 5'b11010, 32'h7FC0_0000, 5'h10);
        runVector("subnormal_rtz",  1'b0, 9'd0,  9'd0,   3'd1, 48'h0555_5500_0005, 1'b1, 1'b0, 5'b00000, 32'h000A_AAAA, 5'h03);
        runVector("subnormal_exact",1'b0, 9'd0,  9'd0,   3'd0, 48'h0555_5500_0000, 1'b1, 1'b0, 5'b00000, 32'h000A_AAAA, 5'h00);
        runVector("rne_carry",      1'b0, 9'd0,  9'd100, 3'd0, 48'hFFFF_FF80_0000, 1'b0, 1'b0, 5'b00000, 32'h3300_0000, 5'h01);
        runVector("rne_tie_even",   1'b1, 9'd0,  9'd126, 3'd0, 48'h8000_0080_0000, 1'b0, 1'b0, 5'b00000, 32'hBF80_0000, 5'h01);
        runVector("rup_sticky",     1'b0, 9'd0,  9'd126, 3'd3, 48'h8000_0000_0001, 1'b0, 1'b0, 5'b00000, 32'h3F80_0001, 5'h01);
        runVector("rdn_negative",   1'b1, 9'd0,  9'd126, 3'd2, 48'h8000_0000_0001, 1'b0, 1'b0, 5'b00000, 32'hBF80_0001, 5'h01);
        runVector("rmm_tie",        1'b0, 9'd0,  9'd126, 3'd4, 48'h8000_0080_0000, 1'b0, 1'b0, 5'b00000, 32'h3F80_0001, 5'h01);
        runVector("rm5_as_rne",     1'b0, 9'd0,  9'd100, 3'd5, 48'hFFFF_FF80_0000, 1'b0, 1'b0, 5'b00000, 32'h3300_0000, 5'h01);
        runVector("max_finite_rtz", 1'b0, 9'd0,  9'd253, 3'd1, 48'hFFFF_FF80_0000, 1'b0, 1'b0, 5'b00000, 32'h7F7F_FFFF, 5'h01);
        runVector("round_ovf_rne",  1'b0, 9'd0,  9'd253, 3'd0, 48'hFFFF_FF80_0000, 1'b0, 1'b0, 5'b00000, 32'h7F80_0000, 5'h05);
        runVector("round_ovf_rdn",  1'b1, 9'd0,  9'd253, 3'd2, 48'hFFFF_FF80_0000, 1'b0, 1'b0, 5'b00000, 32'hFF80_0000, 5'h05);
        runVector("special_inf",    1'b1, 9'd0,  9'd0,   3'd0, 48'h0,              1'b0, 1'b0, 5'b10100, 32'hFF80_0000, 5'h00);
        runVector("special_zero",   1'b1, 9'd0,  9'd0,   3'd0, 48'h0,              1'b0, 1'b0, 5'b10001, 32'h8000_0000, 5'h00);
        runVector("shift23",        1'b0, 9'd23, 9'd126, 3'd0, 48'h0000_0080_0000, 1'b0, 1'b0, 5'b00000, 32'h3F00_0000, 5'h00);
        @(posedge clk);
        #1;
        checkValue("drain valid", {31'd0, out_valid_o}, 32'd0);

        // Backpressure: A is held while B waits; releasing the stall swaps A for B in one edge
        applyStimulus(1'b0, 9'd1, 9'd100, 3'd0, 48'h4000_0000_0000, 1'b0, 1'b0, 5'b00000);
        out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 9'd1, 9'd110, 3'd0, 48'h4000_0000_0000, 1'b0, 1'b0, 5'b00000);
        out_ready_i = 1'b0;
        accepts = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (in_valid_i && in_ready_o) accepts++;
            @(posedge clk);
            #1;
            checkValue("stall valid", {31'd0, out_valid_o}, 32'd1);
            checkValue("stall result", result_o, 32'h3280_0000);
        end
        checkValue("stall extra accepts", 32'(accepts), 32'd0);
        out_ready_i = 1'b1;
        #1;
        checkValue("ready on drain", {31'd0, in_ready_o}, 32'd1);
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        checkOutput("replace_no_bubble", 32'h3780_0000, 5'h00);
        @(posedge clk);
        #1;
        checkValue("replace drained", {31'd0, out_valid_o}, 32'd0);

        // Ten back-to-back transfers checked in order against a scoreboard
        sent = 0;
        got  = 0;
        for (int c = 0; c < 30; c++) begin
            if (out_valid_o) begin
                checkValue("stream nonempty", {31'd0, q.size() > 0}, 32'd1);
                if (q.size() > 0) begin
                    checkValue("stream result", result_o, q.pop_front());
                    got++;
                end
            end
            if (sent < 10) begin
                applyStimulus(sent[0], 9'd1, 9'(50 + sent), 3'd0,
                              48'h4000_0000_0000 | (48'(sent) << 23), 1'b0, 1'b0, 5'b00000);
            end else begin
                in_valid_i = 1'b0;
            end
            #1;
            if (in_valid_i && in_ready_o) begin
                q.push_back({sent[0], 8'(51 + sent), 23'(sent)});
                sent++;
            end
            @(posedge clk);
            #1;
        end
        checkValue("stream sent", 32'(sent), 32'd10);
        checkValue("stream received", 32'(got), 32'd10);

        // Reset while a result is held must drop it
        applyStimulus(1'b0, 9'd1, 9'd126, 3'd0, 48'h4000_0000_0000, 1'b0, 1'b0, 5'b00000);
        out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        checkValue("pre-reset valid", {31'd0, out_valid_o}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkValue("mid-reset valid", {31'd0, out_valid_o}, 32'd0);
        checkValue("mid-reset result", result_o, 32'd0);
        checkValue("mid-reset fflags", {27'd0, fflags_o}, 32'd0);
        checkValue("mid-reset ready", {31'd0, in_ready_o}, 32'd1);
        @(posedge clk);
        #1;
        checkValue("after-reset valid", {31'd0, out_valid_o}, 32'd0);
        checkValue("after-reset ready", {31'd0, in_ready_o}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
